// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock store-and-forward packet FIFO with FWFT read and per-packet commit/drop.
// Optional feature macro SYNC_PKT_FIFO_DROP_CNT_EN builds a saturating drop counter shown on dbg[31:16].
module sync_pkt_fifo #(
  parameter int DWID      = 64,
  parameter int AWID      = 9,
  parameter int AFULL_TH  = 16,
  parameter int AEMPTY_TH = 4,
  parameter int DBG_WID   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic [DWID-1:0]    wdata,
  input  logic               weop,
  input  logic               werr,
  output logic               nfull,
  output logic               nafull,
  output logic               woverflow,
  output logic               wdrop,
  output logic [AWID:0]      cnt_used,
  input  logic               ren,
  output logic [DWID-1:0]    rdata,
  output logic               reop,
  output logic               nempty,
  output logic               naempty,
  output logic               roverflow,
  output logic [AWID:0]      cnt_pkt,
  output logic [DBG_WID-1:0] dbg
);

  localparam int            DEPTH      = 1 << AWID;
  localparam logic [AWID:0] PTR_ONE    = (AWID+1)'(1);
  localparam logic [AWID:0] FULL_LVL   = (AWID+1)'(DEPTH);
  localparam logic [AWID:0] AFULL_LVL  = (AWID+1)'(DEPTH - AFULL_TH);
  localparam logic [AWID:0] AEMPTY_LVL = (AWID+1)'(AEMPTY_TH);

  // Storage: eop rides in the top bit of each word.
  logic [DWID:0] mem [DEPTH];
  logic [DWID:0] ram_q_reg;

  logic [AWID:0] wptr_tmp_reg, wptr_tmp_next;
  logic [AWID:0] wptr_cmt_reg, wptr_cmt_next;
  logic [AWID:0] rptr_ram_reg, rptr_ram_next;
  logic [AWID:0] rptr_pop_reg, rptr_pop_next;
  logic [AWID:0] cnt_pkt_reg, cnt_pkt_next;
  logic [AWID:0] cnt_used_reg;
  logic [AWID:0] occ_next;
  logic [AWID:0] cmt_words;
  logic          bad_reg, bad_next;
  logic          nfull_reg, nafull_reg;
  logic          woverflow_reg, roverflow_reg, wdrop_reg;
  logic          rd_vld_reg, out_vld_reg, out_eop_reg;
  logic [DWID-1:0] out_data_reg;
  logic [31:0]   dbg_reg;
  logic [15:0]   drop_cnt;

  logic wr_acc, wr_full, drop, commit, pop, pop_eop, out_load, prefetch;

  always_comb begin
    wr_acc   = wen & nfull_reg;
    wr_full  = wen & ~nfull_reg;
    // An eop that lands on a full FIFO also kills its packet.
    drop     = wen & weop & (werr | bad_reg | ~nfull_reg);
    commit   = wen & weop & nfull_reg & ~werr & ~bad_reg;
    pop      = ren & out_vld_reg;
    pop_eop  = pop & out_eop_reg;
    out_load = rd_vld_reg & (~out_vld_reg | pop);
    // The RAM read register and the output register together form a two-word skid.
    prefetch = (~rd_vld_reg | out_load) & (rptr_ram_reg != wptr_cmt_reg);
  end

  always_comb begin
    wptr_tmp_next = wptr_tmp_reg;
    if (drop)
      wptr_tmp_next = wptr_cmt_reg;
    else if (wr_acc)
      wptr_tmp_next = wptr_tmp_reg + PTR_ONE;

    wptr_cmt_next = commit   ? (wptr_tmp_reg + PTR_ONE) : wptr_cmt_reg;
    rptr_ram_next = prefetch ? (rptr_ram_reg + PTR_ONE) : rptr_ram_reg;
    rptr_pop_next = pop      ? (rptr_pop_reg + PTR_ONE) : rptr_pop_reg;
    occ_next      = wptr_tmp_next - rptr_pop_next;

    cnt_pkt_next = cnt_pkt_reg;
    case ({commit, pop_eop})
      2'b10:   cnt_pkt_next = cnt_pkt_reg + PTR_ONE;
      2'b01:   cnt_pkt_next = cnt_pkt_reg - PTR_ONE;
      default: cnt_pkt_next = cnt_pkt_reg;
    endcase

    bad_next = bad_reg;
    if (drop)
      bad_next = 1'b0;
    else if (wr_full)
      bad_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr_tmp_reg[AWID-1:0]] <= {weop, wdata};
    if (prefetch)
      ram_q_reg <= mem[rptr_ram_reg[AWID-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_tmp_reg  <= '0;
      wptr_cmt_reg  <= '0;
      rptr_ram_reg  <= '0;
      rptr_pop_reg  <= '0;
      cnt_pkt_reg   <= '0;
      cnt_used_reg  <= '0;
      bad_reg       <= 1'b0;
      nfull_reg     <= 1'b1;
      nafull_reg    <= 1'b1;
      woverflow_reg <= 1'b0;
      roverflow_reg <= 1'b0;
      wdrop_reg     <= 1'b0;
    end else begin
      wptr_tmp_reg  <= wptr_tmp_next;
      wptr_cmt_reg  <= wptr_cmt_next;
      rptr_ram_reg  <= rptr_ram_next;
      rptr_pop_reg  <= rptr_pop_next;
      cnt_pkt_reg   <= cnt_pkt_next;
      cnt_used_reg  <= occ_next;
      bad_reg       <= bad_next;
      nfull_reg     <= (occ_next != FULL_LVL);
      nafull_reg    <= (occ_next < AFULL_LVL);
      woverflow_reg <= woverflow_reg | wr_full;
      roverflow_reg <= roverflow_reg | (ren & ~out_vld_reg);
      wdrop_reg     <= drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_reg   <= 1'b0;
      out_vld_reg  <= 1'b0;
      out_eop_reg  <= 1'b0;
      out_data_reg <= '0;
    end else begin
      if (prefetch)
        rd_vld_reg <= 1'b1;
      else if (out_load)
        rd_vld_reg <= 1'b0;

      if (out_load) begin
        out_vld_reg  <= 1'b1;
        out_eop_reg  <= ram_q_reg[DWID];
        out_data_reg <= ram_q_reg[DWID-1:0];
      end else if (pop) begin
        out_vld_reg <= 1'b0;
      end
    end
  end

`ifdef SYNC_PKT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != 16'hFFFF))
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 16'h0000;
`endif

  // Debug word is a registered snapshot, so it reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbg_reg <= '0;
    else
      dbg_reg <= {drop_cnt, 12'h000, woverflow_reg, roverflow_reg, nafull_reg, out_vld_reg};
  end

  assign dbg[31:0] = dbg_reg;
  generate
    for (genvar gi = 32; gi < DBG_WID; gi++) begin : g_dbg_pad
      assign dbg[gi] = 1'b0;
    end
  endgenerate

  assign cmt_words = wptr_cmt_reg - rptr_pop_reg;

  assign nfull     = nfull_reg;
  assign nafull    = nafull_reg;
  assign woverflow = woverflow_reg;
  assign wdrop     = wdrop_reg;
  assign cnt_used  = cnt_used_reg;
  assign rdata     = out_data_reg;
  assign reop      = out_eop_reg;
  assign nempty    = out_vld_reg;
  assign naempty   = (cmt_words > AEMPTY_LVL);
  assign roverflow = roverflow_reg;
  assign cnt_pkt   = cnt_pkt_reg;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// tb_sync_pkt_fifo: directed scenario tests for sync_pkt_fifo at AWID=4 (16-word depth).
// Expected drop counter value follows SYNC_PKT_FIFO_DROP_CNT_EN.
module tb_sync_pkt_fifo;
  localparam int DWID = 16, AWID = 4, AFULL_TH = 4, AEMPTY_TH = 2, DBG_WID = 32;
`ifdef SYNC_PKT_FIFO_DROP_CNT_EN
  localparam logic [31:0] DC_UNIT = 32'h0001_0000;
`else
  localparam logic [31:0] DC_UNIT = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n, wen, weop, werr, ren;
  logic [DWID-1:0] wdata;
  logic nfull, nafull, woverflow, wdrop, reop, nempty, naempty, roverflow;
  logic [AWID:0] cnt_used, cnt_pkt;
  logic [DWID-1:0] rdata;
  logic [DBG_WID-1:0] dbg;
  int checks = 0;
  int errors = 0;

  sync_pkt_fifo #(.DWID(DWID), .AWID(AWID), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .DBG_WID(DBG_WID)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .weop(weop), .werr(werr),
    .nfull(nfull), .nafull(nafull), .woverflow(woverflow), .wdrop(wdrop), .cnt_used(cnt_used),
    .ren(ren), .rdata(rdata), .reop(reop), .nempty(nempty), .naempty(naempty),
    .roverflow(roverflow), .cnt_pkt(cnt_pkt), .dbg(dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [DWID-1:0] d, input logic eop, input logic err);
    wen = 1'b1; wdata = d; weop = eop; werr = err;
    tick();
    $display("write data=%h eop=%0b err=%0b ren=%0b -> used=%0d pkt=%0d", d, eop, err, ren, cnt_used, cnt_pkt);
    wen = 1'b0; weop = 1'b0; werr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wen = 1'b0; weop = 1'b0; werr = 1'b0; ren = 1'b0; wdata = '0;
    repeat (3) tick();
    checks++; if (nfull !== 1'b1)     begin errors++; $display("FAIL rst_nfull got %0b want 1", nfull); end
    checks++; if (nafull !== 1'b1)    begin errors++; $display("FAIL rst_nafull got %0b want 1", nafull); end
    checks++; if (nempty !== 1'b0)    begin errors++; $display("FAIL rst_nempty got %0b want 0", nempty); end
    checks++; if (naempty !== 1'b0)   begin errors++; $display("FAIL rst_naempty got %0b want 0", naempty); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL rst_woverflow got %0b want 0", woverflow); end
    checks++; if (roverflow !== 1'b0) begin errors++; $display("FAIL rst_roverflow got %0b want 0", roverflow); end
    checks++; if (wdrop !== 1'b0)     begin errors++; $display("FAIL rst_wdrop got %0b want 0", wdrop); end
    checks++; if (rdata !== 16'h0)    begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
    checks++; if (reop !== 1'b0)      begin errors++; $display("FAIL rst_reop got %0b want 0", reop); end
    checks++; if (cnt_used !== 5'd0)  begin errors++; $display("FAIL rst_cnt_used got %0d want 0", cnt_used); end
    checks++; if (cnt_pkt !== 5'd0)   begin errors++; $display("FAIL rst_cnt_pkt got %0d want 0", cnt_pkt); end
    checks++; if (dbg !== 32'h0)      begin errors++; $display("FAIL rst_dbg got %h want 0", dbg); end
    $display("reset checked");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_commit();
    wr_word(16'hA000, 1'b0, 1'b0);
    wr_word(16'hA001, 1'b0, 1'b0);
    wr_word(16'hA002, 1'b1, 1'b0);
    checks++; if (cnt_pkt !== 5'd1)  begin errors++; $display("FAIL commit_cnt_pkt got %0d want 1", cnt_pkt); end
    checks++; if (cnt_used !== 5'd3) begin errors++; $display("FAIL commit_cnt_used got %0d want 3", cnt_used); end
    checks++; if (nempty !== 1'b0)   begin errors++; $display("FAIL commit_nempty_k got %0b want 0", nempty); end
    tick();
    checks++; if (nempty !== 1'b0)   begin errors++; $display("FAIL commit_nempty_k1 got %0b want 0", nempty); end
    tick();
    checks++; if (nempty !== 1'b1)   begin errors++; $display("FAIL commit_nempty_k2 got %0b want 1", nempty); end
    ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdata !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL commit_rdata%0d got %h want %h", i, rdata, 16'hA000 + 16'(i)); end
      checks++; if (reop !== (i == 2))           begin errors++; $display("FAIL commit_reop%0d got %0b want %0b", i, reop, (i == 2)); end
      checks++; if (naempty !== (i == 0))        begin errors++; $display("FAIL commit_naempty%0d got %0b want %0b", i, naempty, (i == 0)); end
      tick();
      $display("pop data=%h", 16'hA000 + 16'(i));
    end
    ren = 1'b0;
    checks++; if (nempty !== 1'b0)   begin errors++; $display("FAIL commit_drained_nempty got %0b want 0", nempty); end
    checks++; if (cnt_pkt !== 5'd0)  begin errors++; $display("FAIL commit_drained_pkt got %0d want 0", cnt_pkt); end
    checks++; if (cnt_used !== 5'd0) begin errors++; $display("FAIL commit_drained_used got %0d want 0", cnt_used); end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 4; i++) wr_word(16'hD000 + 16'(i), 1'b0, 1'b0);
    checks++; if (cnt_used !== 5'd4) begin errors++; $display("FAIL drop_used_pre got %0d want 4", cnt_used); end
    wr_word(16'hD004, 1'b1, 1'b1);
    checks++; if (wdrop !== 1'b1)    begin errors++; $display("FAIL drop_wdrop got %0b want 1", wdrop); end
    checks++; if (cnt_used !== 5'd0) begin errors++; $display("FAIL drop_used got %0d want 0", cnt_used); end
    checks++; if (cnt_pkt !== 5'd0)  begin errors++; $display("FAIL drop_pkt got %0d want 0", cnt_pkt); end
    tick();
    checks++; if (wdrop !== 1'b0)    begin errors++; $display("FAIL drop_wdrop_end got %0b want 0", wdrop); end
    repeat (2) tick();
    checks++; if (nempty !== 1'b0)   begin errors++; $display("FAIL drop_nempty got %0b want 0", nempty); end
    checks++; if (dbg !== (DC_UNIT | 32'h2)) begin errors++; $display("FAIL drop_dbg got %h want %h", dbg, DC_UNIT | 32'h2); end
  endtask

  task automatic test_back_to_back();
    logic [DWID-1:0] exp_d [4] = '{16'hB000, 16'hB001, 16'hC000, 16'hC001};
    logic            exp_e [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [AWID:0]   exp_p [4] = '{5'd2, 5'd2, 5'd1, 5'd1};
    for (int i = 0; i < 4; i++) wr_word(exp_d[i], exp_e[i], 1'b0);
    repeat (2) tick();
    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (nempty !== 1'b1)     begin errors++; $display("FAIL b2b_nempty%0d got %0b want 1", i, nempty); end
      checks++; if (rdata !== exp_d[i])  begin errors++; $display("FAIL b2b_rdata%0d got %h want %h", i, rdata, exp_d[i]); end
      checks++; if (reop !== exp_e[i])   begin errors++; $display("FAIL b2b_reop%0d got %0b want %0b", i, reop, exp_e[i]); end
      checks++; if (cnt_pkt !== exp_p[i]) begin errors++; $display("FAIL b2b_pkt%0d got %0d want %0d", i, cnt_pkt, exp_p[i]); end
      tick();
      $display("pop data=%h eop=%0b", exp_d[i], exp_e[i]);
    end
    ren = 1'b0;
    checks++; if (nempty !== 1'b0)  begin errors++; $display("FAIL b2b_end_nempty got %0b want 0", nempty); end
    checks++; if (cnt_pkt !== 5'd0) begin errors++; $display("FAIL b2b_end_pkt got %0d want 0", cnt_pkt); end
  endtask

  task automatic test_ren_empty();
    ren = 1'b1;
    tick();
    ren = 1'b0;
    $display("pop attempted while empty");
    checks++; if (roverflow !== 1'b1) begin errors++; $display("FAIL rovf_set got %0b want 1", roverflow); end
    checks++; if (cnt_used !== 5'd0)  begin errors++; $display("FAIL rovf_used got %0d want 0", cnt_used); end
    checks++; if (cnt_pkt !== 5'd0)   begin errors++; $display("FAIL rovf_pkt got %0d want 0", cnt_pkt); end
    repeat (3) tick();
    checks++; if (roverflow !== 1'b1) begin errors++; $display("FAIL rovf_sticky got %0b want 1", roverflow); end
  endtask

  task automatic test_commit_pop();
    wr_word(16'hE000, 1'b1, 1'b0);
    repeat (2) tick();
    checks++; if (rdata !== 16'hE000) begin errors++; $display("FAIL cp_first got %h want E000", rdata); end
    ren = 1'b1;
    wr_word(16'h0D00, 1'b1, 1'b0);
    ren = 1'b0;
    checks++; if (cnt_pkt !== 5'd1) begin errors++; $display("FAIL cp_pkt got %0d want 1", cnt_pkt); end
    checks++; if (nempty !== 1'b0)  begin errors++; $display("FAIL cp_nempty0 got %0b want 0", nempty); end
    tick();
    checks++; if (nempty !== 1'b0)  begin errors++; $display("FAIL cp_nempty1 got %0b want 0", nempty); end
    tick();
    checks++; if (nempty !== 1'b1)    begin errors++; $display("FAIL cp_nempty2 got %0b want 1", nempty); end
    checks++; if (rdata !== 16'h0D00) begin errors++; $display("FAIL cp_rdata got %h want 0D00", rdata); end
    checks++; if (reop !== 1'b1)      begin errors++; $display("FAIL cp_reop got %0b want 1", reop); end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    $display("pop data=0d00 eop=1");
    checks++; if (cnt_pkt !== 5'd0) begin errors++; $display("FAIL cp_pkt_end got %0d want 0", cnt_pkt); end
  endtask

  task automatic test_full_exact();
    for (int i = 0; i < 15; i++) wr_word(16'hF000 + 16'(i), (i == 14), 1'b0);
    checks++; if (cnt_used !== 5'd15) begin errors++; $display("FAIL fx_used15 got %0d want 15", cnt_used); end
    checks++; if (nfull !== 1'b1)     begin errors++; $display("FAIL fx_nfull15 got %0b want 1", nfull); end
    checks++; if (nafull !== 1'b0)    begin errors++; $display("FAIL fx_nafull15 got %0b want 0", nafull); end
    repeat (2) tick();
    ren = 1'b1;
    wr_word(16'h7000, 1'b0, 1'b0);
    ren = 1'b0;
    checks++; if (cnt_used !== 5'd15) begin errors++; $display("FAIL fx_wrpop_used got %0d want 15", cnt_used); end
    checks++; if (nfull !== 1'b1)     begin errors++; $display("FAIL fx_wrpop_nfull got %0b want 1", nfull); end
    wr_word(16'h7001, 1'b0, 1'b0);
    checks++; if (cnt_used !== 5'd16) begin errors++; $display("FAIL fx_used16 got %0d want 16", cnt_used); end
    checks++; if (nfull !== 1'b0)     begin errors++; $display("FAIL fx_nfull16 got %0b want 0", nfull); end
    ren = 1'b1;
    for (int i = 1; i < 15; i++) begin
      checks++; if (rdata !== 16'hF000 + 16'(i)) begin errors++; $display("FAIL fx_rdata%0d got %h want %h", i, rdata, 16'hF000 + 16'(i)); end
      tick();
      $display("pop data=%h", 16'hF000 + 16'(i));
    end
    ren = 1'b0;
    checks++; if (cnt_used !== 5'd2) begin errors++; $display("FAIL fx_used_tail got %0d want 2", cnt_used); end
    checks++; if (nempty !== 1'b0)   begin errors++; $display("FAIL fx_nempty_tail got %0b want 0", nempty); end
    wr_word(16'h7002, 1'b1, 1'b0);
    repeat (2) tick();
    ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdata !== 16'h7000 + 16'(i)) begin errors++; $display("FAIL fx_tail%0d got %h want %h", i, rdata, 16'h7000 + 16'(i)); end
      tick();
      $display("pop data=%h", 16'h7000 + 16'(i));
    end
    ren = 1'b0;
    checks++; if (cnt_used !== 5'd0) begin errors++; $display("FAIL fx_used_end got %0d want 0", cnt_used); end
    checks++; if (nafull !== 1'b1)   begin errors++; $display("FAIL fx_nafull_end got %0b want 1", nafull); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_word(16'h5000 + 16'(i), 1'b0, 1'b0);
      checks++; if (nafull !== (i + 1 < 12)) begin errors++; $display("FAIL ovf_nafull%0d got %0b want %0b", i, nafull, (i + 1 < 12)); end
    end
    checks++; if (nfull !== 1'b0)     begin errors++; $display("FAIL ovf_nfull got %0b want 0", nfull); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0b want 0", woverflow); end
    wr_word(16'h5FFF, 1'b1, 1'b0);
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", woverflow); end
    checks++; if (wdrop !== 1'b1)     begin errors++; $display("FAIL ovf_wdrop got %0b want 1", wdrop); end
    tick();
    checks++; if (nfull !== 1'b1)     begin errors++; $display("FAIL ovf_nfull_rec got %0b want 1", nfull); end
    checks++; if (nafull !== 1'b1)    begin errors++; $display("FAIL ovf_nafull_rec got %0b want 1", nafull); end
    checks++; if (cnt_used !== 5'd0)  begin errors++; $display("FAIL ovf_used got %0d want 0", cnt_used); end
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", woverflow); end
    checks++; if (nempty !== 1'b0)    begin errors++; $display("FAIL ovf_nempty got %0b want 0", nempty); end
    repeat (2) tick();
    checks++; if (dbg !== (DC_UNIT * 2 | 32'hE)) begin errors++; $display("FAIL ovf_dbg got %h want %h", dbg, DC_UNIT * 2 | 32'hE); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_drop();
    test_back_to_back();
    test_ren_empty();
    test_commit_pop();
    test_full_exact();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
